// File: rtl/updown_counter_pkg.sv
// Shared types and next-count arithmetic for the up/down counter.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package updown_counter_pkg;

    // Arithmetic width: widest counter (16 bits) plus one guard bit.
    localparam int CALC_W = 17;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    typedef struct packed {
        logic [CALC_W-1:0] count;
        logic              tc;
    } next_t;

    // Next count and terminal-count flag for one tick. The guard bit keeps
    // count+step and count+MAX_VAL+1 from overflowing for any legal width.
    function automatic next_t next_count(
        input logic [CALC_W-1:0] cnt,
        input logic [CALC_W-1:0] s,
        input logic              up,
        input mode_e             mode,
        input logic [CALC_W-1:0] max_val
    );
        next_t             r;
        logic [CALC_W-1:0] sum;
        r.count = cnt;
        r.tc    = 1'b0;
        if (up == DIR_UP) begin
            sum = cnt + s;
            if (sum <= max_val) begin
                r.count = sum;
            end else begin
                r.tc    = 1'b1;
                r.count = (mode == MODE_SAT) ? max_val : sum - (max_val + 1'b1);
            end
        end else begin
            if (cnt >= s) begin
                r.count = cnt - s;
            end else begin
                r.tc    = 1'b1;
                r.count = (mode == MODE_SAT) ? '0 : cnt + max_val + 1'b1 - s;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Clock-enable prescaler: one tick per presc+1 enabled cycles.
// Latency: tick is combinational from en and the registered phase count.
// Backpressure: en low freezes the phase; clr restarts the period.
module counter_prescaler #(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] phase;

    // >= rather than == so lowering presc mid-period cannot strand the phase
    assign tick = en && (phase >= presc);

    // Phase counter: restart on terminal, advance on enabled cycles only
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            phase <= '0;
        end else if (tick) begin
            phase <= '0;
        end else if (en) begin
            phase <= phase + 1'b1;
        end
    end

endmodule

// File: rtl/updown_counter_gen.sv
// Parametrised up/down counter with load, wrap/saturate and tc pulse.
// Latency: 1 cycle from load or tick to count/tc; flags combinational.
// Backpressure: en low freezes count and prescaler; UPDOWN_COUNTER_PRESCALE_EN adds the prescaler.
module updown_counter_gen
    import updown_counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 255,
    parameter int STEP_W  = 4,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               up,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [STEP_W-1:0]  step,
    input  logic               sat_mode,
    input  logic [PRESC_W-1:0] presc,
    output logic [WIDTH-1:0]   count,
    output logic               tc,
    output logic               at_max,
    output logic               at_min
);

    localparam logic [WIDTH-1:0]  MAX_W   = WIDTH'(MAX_VAL);
    localparam logic [CALC_W-1:0] MAX_EXT = CALC_W'(MAX_VAL);

    logic             tick;
    logic [WIDTH-1:0] load_clamped;
    next_t            nxt;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
    counter_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (load),
        .presc (presc),
        .tick  (tick)
    );
`else
    // presc is kept on the port list for pin compatibility but has no effect
    logic presc_unused;
    assign presc_unused = ^presc;
    assign tick         = en;
`endif

    assign load_clamped = (load_val > MAX_W) ? MAX_W : load_val;
    assign nxt          = next_count(CALC_W'(count), CALC_W'(step), up,
                                     mode_e'(sat_mode), MAX_EXT);

    assign at_max = (count == MAX_W);
    assign at_min = (count == '0);

    // Count and tc register: reset > load > tick > hold; tc pulses only on a tick
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            tc    <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            tc    <= 1'b0;
        end else if (tick) begin
            count <= WIDTH'(nxt.count);
            tc    <= nxt.tc;
        end else begin
            tc    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_updown_counter_gen.sv
// Scoreboard bench for updown_counter_gen with a spec-level reference model.
// Latency: expectations are queued one edge ahead of the monitor.
// Backpressure: not applicable; the monitor checks every cycle.
module tb_updown_counter_gen;

    localparam int WIDTH   = 8;
    localparam int MAX_VAL = 199;
    localparam int STEP_W  = 4;
    localparam int PRESC_W = 4;

    logic               clk = 1'b0;
    logic               reset, en, up, load, sat_mode;
    logic [WIDTH-1:0]   load_val;
    logic [STEP_W-1:0]  step;
    logic [PRESC_W-1:0] presc;
    logic [WIDTH-1:0]   count;
    logic               tc, at_max, at_min;

    typedef struct {
        int cnt;
        bit tc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_cnt    = 0;
    int   m_presc  = 0;

    always #5 clk = ~clk;

    updown_counter_gen #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .STEP_W  (STEP_W),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .step     (step),
        .sat_mode (sat_mode),
        .presc    (presc),
        .count    (count),
        .tc       (tc),
        .at_max   (at_max),
        .at_min   (at_min)
    );

    // Reference model: apply the current inputs to the model state, queue the
    // expected post-edge outputs, then advance one clock.
    task automatic tick_clk();
        exp_t e;
        int   s;
        bit   tk;
        e.tc = 1'b0;
        if (reset) begin
            m_cnt   = 0;
            m_presc = 0;
        end else if (load) begin
            m_cnt   = (int'(load_val) > MAX_VAL) ? MAX_VAL : int'(load_val);
            m_presc = 0;
        end else begin
`ifdef UPDOWN_COUNTER_PRESCALE_EN
            tk = en && (m_presc >= int'(presc));
            if (en) m_presc = tk ? 0 : m_presc + 1;
`else
            tk = en;
`endif
            if (tk) begin
                s = int'(step);
                if (up) begin
                    if (m_cnt + s <= MAX_VAL) begin
                        m_cnt = m_cnt + s;
                    end else begin
                        e.tc  = 1'b1;
                        m_cnt = sat_mode ? MAX_VAL : m_cnt + s - (MAX_VAL + 1);
                    end
                end else begin
                    if (m_cnt >= s) begin
                        m_cnt = m_cnt - s;
                    end else begin
                        e.tc  = 1'b1;
                        m_cnt = sat_mode ? 0 : m_cnt + (MAX_VAL + 1) - s;
                    end
                end
            end
        end
        e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: after every edge, pop the oldest expectation and compare
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (count === WIDTH'(e.cnt) && tc === e.tc &&
                    at_max === (e.cnt == MAX_VAL) && at_min === (e.cnt == 0)) begin
                    n_pass++;
                end else begin
                    $display("FAIL counter_out t=%0t: got count=%0d tc=%0b at_max=%0b at_min=%0b, expected count=%0d tc=%0b at_max=%0b at_min=%0b",
                             $time, count, tc, at_max, at_min, e.cnt, e.tc,
                             e.cnt == MAX_VAL, e.cnt == 0);
                end
            end
        end
    end

    // Stimulus: directed boundary cases, then randomized traffic
    initial begin
        reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; sat_mode = 1'b0;
        load_val = '0; step = STEP_W'(1); presc = '0;
        tick_clk();
        tick_clk();
        reset = 1'b0;

        // Count up by one through the wrap at MAX_VAL
        en = 1'b1; up = 1'b1; step = STEP_W'(1);
        repeat (205) tick_clk();

        // Down by 3 with wrap from a low load
        load = 1'b1; load_val = WIDTH'(1); tick_clk(); load = 1'b0;
        up = 1'b0; step = STEP_W'(3); sat_mode = 1'b0;
        repeat (8) tick_clk();

        // Saturate up, hold at the limit, then step back down
        load = 1'b1; load_val = WIDTH'(MAX_VAL - 4); tick_clk(); load = 1'b0;
        up = 1'b1; step = STEP_W'(4); sat_mode = 1'b1;
        repeat (5) tick_clk();
        up = 1'b0;
        repeat (2) tick_clk();

        // Clamped load with en high, then reset overriding load
        load = 1'b1; en = 1'b1; load_val = WIDTH'(250); tick_clk();
        reset = 1'b1; load_val = WIDTH'(50); tick_clk();
        reset = 1'b0; load = 1'b0;
        load = 1'b1; load_val = WIDTH'(100); tick_clk(); load = 1'b0;

        // en low freezes everything while direction toggles
        en = 1'b0; step = STEP_W'(5);
        for (int i = 0; i < 10; i++) begin
            up = 1'(i % 2);
            tick_clk();
        end

        // Prescaler period, en gap mid-period, then presc lowered
        presc = PRESC_W'(3); en = 1'b1; up = 1'b1; step = STEP_W'(1); sat_mode = 1'b0;
        repeat (10) tick_clk();
        en = 1'b0; repeat (2) tick_clk();
        en = 1'b1; repeat (6) tick_clk();
        tick_clk();
        presc = '0; repeat (4) tick_clk();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(63) == 0);
            load     = ($urandom_range(15) == 0);
            en       = ($urandom_range(3) != 0);
            up       = 1'($urandom_range(1));
            sat_mode = 1'($urandom_range(1));
            load_val = WIDTH'($urandom_range(255));
            step     = STEP_W'($urandom_range(15));
            presc    = ($urandom_range(7) == 0) ? PRESC_W'($urandom_range(15))
                                                : PRESC_W'($urandom_range(2));
            tick_clk();
        end

        reset = 1'b0; load = 1'b0; en = 1'b0;
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
